// File: rtl/bank_burst_ctrl.sv
// Per-bank command sequencer: tracks the open row and expands RD/WR commands
// into BL single-beat array accesses using wrap-around (sequential) column order.
module bank_burst_ctrl #(
    parameter int DEVICE_WIDTH = 4,
    parameter int ROWS         = 131072,
    parameter int COLS         = 1024,
    parameter int BL           = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [2:0]               cmd_op,
    input  logic [$clog2(ROWS)-1:0]  cmd_row,
    input  logic [$clog2(COLS)-1:0]  cmd_col,
    input  logic [DEVICE_WIDTH-1:0]  wr_data,
    output logic                     wr_data_ready,
    output logic [DEVICE_WIDTH-1:0]  rd_data,
    output logic                     rd_valid,
    output logic                     row_open,
    output logic [$clog2(ROWS)-1:0]  open_row,
    output logic                     err,
    output logic                     bank_rd_o_wr,
    output logic [DEVICE_WIDTH-1:0]  bank_dqin,
    input  logic [DEVICE_WIDTH-1:0]  bank_dqout,
    output logic [$clog2(ROWS)-1:0]  bank_row,
    output logic [$clog2(COLS)-1:0]  bank_column
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int BW = $clog2(BL);
    localparam logic [CW-1:0] LOW_MASK  = CW'(BL - 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BL - 1);

    localparam logic [2:0] OP_ACT = 3'd0;
    localparam logic [2:0] OP_PR  = 3'd1;
    localparam logic [2:0] OP_RD  = 3'd2;
    localparam logic [2:0] OP_RDA = 3'd3;
    localparam logic [2:0] OP_WR  = 3'd4;
    localparam logic [2:0] OP_WRA = 3'd5;

    typedef enum logic [1:0] {IDLE, ACTIVE, RD_BURST, WR_BURST} state_t;

    state_t          stateQ, stateD;
    logic            rowOpenQ, rowOpenD;
    logic [RW-1:0]   openRowQ, openRowD;
    logic [CW-1:0]   colQ, colD;
    logic [BW-1:0]   beatQ, beatD;
    logic            autoPreQ, autoPreD;
    logic            errQ, errD;
    logic            rdValidQ;
    logic            inBurst, lastBeat, accept, effOpen;

    // The last beat cycle also accepts a command so back-to-back bursts run gap-free.
    assign inBurst   = (stateQ == RD_BURST) || (stateQ == WR_BURST);
    assign lastBeat  = inBurst && (beatQ == LAST_BEAT);
    assign cmd_ready = (stateQ == IDLE) || (stateQ == ACTIVE) || lastBeat;
    assign accept    = cmd_valid && cmd_ready;
    assign effOpen   = rowOpenQ && !(lastBeat && autoPreQ);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ   <= IDLE;
            rowOpenQ <= 1'b0;
            openRowQ <= '0;
            colQ     <= '0;
            beatQ    <= '0;
            autoPreQ <= 1'b0;
            errQ     <= 1'b0;
            rdValidQ <= 1'b0;
        end else begin
            stateQ   <= stateD;
            rowOpenQ <= rowOpenD;
            openRowQ <= openRowD;
            colQ     <= colD;
            beatQ    <= beatD;
            autoPreQ <= autoPreD;
            errQ     <= errD;
            rdValidQ <= (stateQ == RD_BURST);
        end
    end

    always_comb begin
        stateD   = stateQ;
        rowOpenD = rowOpenQ;
        openRowD = openRowQ;
        colD     = colQ;
        beatD    = beatQ;
        autoPreD = autoPreQ;
        errD     = 1'b0;

        if (inBurst) begin
            colD  = (colQ & ~LOW_MASK) | ((colQ + CW'(1)) & LOW_MASK);
            beatD = beatQ + BW'(1);
            if (lastBeat) begin
                beatD    = '0;
                stateD   = autoPreQ ? IDLE : ACTIVE;
                rowOpenD = effOpen;
            end
        end

        // Decode against the state the bank is in once any finishing burst has retired.
        if (accept) begin
            if (!effOpen) begin
                if (cmd_op == OP_ACT) begin
                    openRowD = cmd_row;
                    rowOpenD = 1'b1;
                    stateD   = ACTIVE;
                end else begin
                    errD = 1'b1;
                end
            end else begin
                case (cmd_op)
                    OP_RD, OP_RDA: begin
                        stateD   = RD_BURST;
                        colD     = cmd_col;
                        beatD    = '0;
                        autoPreD = (cmd_op == OP_RDA);
                    end
                    OP_WR, OP_WRA: begin
                        stateD   = WR_BURST;
                        colD     = cmd_col;
                        beatD    = '0;
                        autoPreD = (cmd_op == OP_WRA);
                    end
                    OP_PR: begin
                        rowOpenD = 1'b0;
                        stateD   = IDLE;
                    end
                    default: errD = 1'b1;
                endcase
            end
        end
    end

    assign bank_rd_o_wr  = (stateQ == WR_BURST);
    assign wr_data_ready = bank_rd_o_wr;
    assign bank_dqin     = bank_rd_o_wr ? wr_data : '0;
    assign bank_row      = openRowQ;
    assign bank_column   = colQ;
    assign rd_valid      = rdValidQ;
    assign rd_data       = bank_dqout;
    assign row_open      = rowOpenQ;
    assign open_row      = openRowQ;
    assign err           = errQ;

endmodule
